// File: rtl/alu_dword_seq_pkg.sv
// Shared constants for the double-word sequencer: ALU word width, opcodes
// and sequencer states.
package alu_dword_seq_pkg;

  localparam int unsigned DATA_BUS_WIDTH  = 16;
  localparam int unsigned DWORD_WIDTH     = 2 * DATA_BUS_WIDTH;
  localparam int unsigned ALU_OP_NUM_BITS = 3;

  localparam logic [ALU_OP_NUM_BITS-1:0] ALU_OP_ADD = 3'd0;
  localparam logic [ALU_OP_NUM_BITS-1:0] ALU_OP_SUB = 3'd1;
  localparam logic [ALU_OP_NUM_BITS-1:0] ALU_OP_AND = 3'd2;
  localparam logic [ALU_OP_NUM_BITS-1:0] ALU_OP_OR  = 3'd3;
  localparam logic [ALU_OP_NUM_BITS-1:0] ALU_OP_XOR = 3'd4;
  localparam logic [ALU_OP_NUM_BITS-1:0] ALU_OP_NOP = 3'd7;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LO,
    ST_HI,
    ST_FIX,
    ST_DONE
  } state_t;

  function automatic logic is_arith(input logic [ALU_OP_NUM_BITS-1:0] op);
    return (op == ALU_OP_ADD) || (op == ALU_OP_SUB);
  endfunction

endpackage

// File: rtl/alu_dword_seq_alu.sv
// Single-word combinational ALU; SUB carry=1 means no borrow, unknown ops
// give result 0 with Z=1.
module alu
  import alu_dword_seq_pkg::*;
(
  input  logic [ALU_OP_NUM_BITS-1:0] Alu_Op,
  input  logic [DATA_BUS_WIDTH-1:0]  A,
  input  logic [DATA_BUS_WIDTH-1:0]  B,
  output logic [DATA_BUS_WIDTH-1:0]  result,
  output logic                       Z,
  output logic                       C,
  output logic                       N
);

  logic [DATA_BUS_WIDTH:0] ext;

  always_comb begin
    ext = '0;
    case (Alu_Op)
      ALU_OP_ADD: ext = {1'b0, A} + {1'b0, B};
      ALU_OP_SUB: ext = {1'b0, A} + {1'b0, ~B} + (DATA_BUS_WIDTH+1)'(1);
      ALU_OP_AND: ext = {1'b0, A & B};
      ALU_OP_OR:  ext = {1'b0, A | B};
      ALU_OP_XOR: ext = {1'b0, A ^ B};
      default:    ext = '0;
    endcase
    result = ext[DATA_BUS_WIDTH-1:0];
    C      = ext[DATA_BUS_WIDTH];
    Z      = (ext[DATA_BUS_WIDTH-1:0] == '0);
    N      = ext[DATA_BUS_WIDTH-1];
  end

endmodule

// File: rtl/alu_dword_seq.sv
// 32-bit ADD/SUB sequencer time-multiplexing one 16-bit alu across
// low-half, high-half and carry/borrow-fix passes.
module alu_dword_seq
  import alu_dword_seq_pkg::*;
(
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       Cmd_Valid,
  output logic                       Cmd_Ready,
  input  logic [ALU_OP_NUM_BITS-1:0] Cmd_Op,
  input  logic [DWORD_WIDTH-1:0]     Cmd_A,
  input  logic [DWORD_WIDTH-1:0]     Cmd_B,
  output logic                       Rsp_Valid,
  input  logic                       Rsp_Ready,
  output logic [DWORD_WIDTH-1:0]     Rsp_Result,
  output logic                       Rsp_Z,
  output logic                       Rsp_C,
  output logic                       Rsp_N,
  output logic                       Busy
);

  localparam int unsigned W = DATA_BUS_WIDTH;

  state_t                     state, state_next;
  logic                       cmd_ready;
  logic [ALU_OP_NUM_BITS-1:0] op_q;
  logic [DWORD_WIDTH-1:0]     a_q, b_q;
  logic [W-1:0]               res_lo, res_hi;
  logic                       c_lo, c1;
  logic                       z_q, c_q, n_q;

  logic [ALU_OP_NUM_BITS-1:0] alu_op;
  logic [W-1:0]               alu_a, alu_b, alu_result;
  logic                       alu_z, alu_c, alu_n;
  logic                       accept, need_fix, op_add;

  assign accept   = cmd_ready & Cmd_Valid;
  assign op_add   = (op_q == ALU_OP_ADD);
  // ALU SUB carry is "no borrow", so a low-half borrow shows up as c_lo=0
  assign need_fix = op_add ? c_lo : ~c_lo;

  alu u_alu (
    .Alu_Op (alu_op),
    .A      (alu_a),
    .B      (alu_b),
    .result (alu_result),
    .Z      (alu_z),
    .C      (alu_c),
    .N      (alu_n)
  );

  always_comb begin
    state_next = state;
    alu_op     = ALU_OP_NOP;
    alu_a      = '0;
    alu_b      = '0;
    case (state)
      ST_IDLE: if (accept) state_next = is_arith(Cmd_Op) ? ST_LO : ST_DONE;
      ST_LO: begin
        alu_op     = op_q;
        alu_a      = a_q[W-1:0];
        alu_b      = b_q[W-1:0];
        state_next = ST_HI;
      end
      ST_HI: begin
        alu_op     = op_q;
        alu_a      = a_q[DWORD_WIDTH-1:W];
        alu_b      = b_q[DWORD_WIDTH-1:W];
        state_next = need_fix ? ST_FIX : ST_DONE;
      end
      ST_FIX: begin
        alu_op     = op_q;
        alu_a      = res_hi;
        alu_b      = W'(1);
        state_next = ST_DONE;
      end
      ST_DONE: if (Rsp_Ready) state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      cmd_ready <= 1'b0;
      op_q      <= '0;
      a_q       <= '0;
      b_q       <= '0;
      res_lo    <= '0;
      res_hi    <= '0;
      c_lo      <= 1'b0;
      c1        <= 1'b0;
      z_q       <= 1'b0;
      c_q       <= 1'b0;
      n_q       <= 1'b0;
    end else begin
      state     <= state_next;
      cmd_ready <= (state_next == ST_IDLE);
      case (state)
        ST_IDLE: if (accept) begin
          op_q   <= Cmd_Op;
          a_q    <= Cmd_A;
          b_q    <= Cmd_B;
          res_lo <= '0;
          res_hi <= '0;
          z_q    <= ~is_arith(Cmd_Op);
          c_q    <= 1'b0;
          n_q    <= 1'b0;
        end
        ST_LO: begin
          res_lo <= alu_result;
          c_lo   <= alu_c;
        end
        ST_HI: begin
          res_hi <= alu_result;
          c1     <= alu_c;
          if (!need_fix) begin
            z_q <= alu_z & (res_lo == '0);
            c_q <= alu_c;
            n_q <= alu_n;
          end
        end
        ST_FIX: begin
          res_hi <= alu_result;
          z_q    <= alu_z & (res_lo == '0);
          c_q    <= op_add ? (c1 | alu_c) : (c1 & alu_c);
          n_q    <= alu_n;
        end
        default: ;
      endcase
    end
  end

  assign Cmd_Ready  = cmd_ready;
  assign Rsp_Valid  = (state == ST_DONE);
  assign Busy       = (state != ST_IDLE);
  assign Rsp_Result = {res_hi, res_lo};
  assign Rsp_Z      = z_q;
  assign Rsp_C      = c_q;
  assign Rsp_N      = n_q;

endmodule

// File: tb/tb_alu_dword_seq.sv
// Randomized bench for alu_dword_seq against a plain 33-bit arithmetic model.
module tb_alu_dword_seq;
  import alu_dword_seq_pkg::*;

  logic                       clk = 1'b0;
  logic                       rst;
  logic                       Cmd_Valid;
  logic                       Cmd_Ready;
  logic [ALU_OP_NUM_BITS-1:0] Cmd_Op;
  logic [DWORD_WIDTH-1:0]     Cmd_A, Cmd_B;
  logic                       Rsp_Valid;
  logic                       Rsp_Ready;
  logic [DWORD_WIDTH-1:0]     Rsp_Result;
  logic                       Rsp_Z, Rsp_C, Rsp_N;
  logic                       Busy;

  int unsigned checks   = 0;
  int unsigned failures = 0;

  always #5 clk = ~clk;

  alu_dword_seq dut (
    .clk        (clk),
    .rst        (rst),
    .Cmd_Valid  (Cmd_Valid),
    .Cmd_Ready  (Cmd_Ready),
    .Cmd_Op     (Cmd_Op),
    .Cmd_A      (Cmd_A),
    .Cmd_B      (Cmd_B),
    .Rsp_Valid  (Rsp_Valid),
    .Rsp_Ready  (Rsp_Ready),
    .Rsp_Result (Rsp_Result),
    .Rsp_Z      (Rsp_Z),
    .Rsp_C      (Rsp_C),
    .Rsp_N      (Rsp_N),
    .Busy       (Busy)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference: whole 32-bit arithmetic; latency from whether the low half carries/borrows.
  task automatic model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] r, output logic z, output logic c,
                       output logic n, output int unsigned lat);
    logic [32:0] s;
    bit fix;
    if (op == ALU_OP_ADD) begin
      s   = {1'b0, a} + {1'b0, b};
      r   = s[31:0];
      c   = s[32];
      fix = ({16'h0, a[15:0]} + {16'h0, b[15:0]}) > 32'h0000_FFFF;
      lat = fix ? 4 : 3;
    end else if (op == ALU_OP_SUB) begin
      r   = a - b;
      c   = (a >= b);
      fix = (a[15:0] < b[15:0]);
      lat = fix ? 4 : 3;
    end else begin
      r   = 32'h0;
      c   = 1'b0;
      lat = 1;
    end
    z = (r == 32'h0) || !((op == ALU_OP_ADD) || (op == ALU_OP_SUB));
    n = r[31];
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_cmd(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input int unsigned hold);
    logic [31:0] er;
    logic ez, ec, en;
    int unsigned elat, lat, waited;
    model(op, a, b, er, ez, ec, en, elat);
    waited = 0;
    while (!Cmd_Ready && waited < 50) begin
      tick();
      waited++;
    end
    check("ready_before_cmd", 32'(Cmd_Ready), 32'd1);
    Cmd_Valid = 1'b1;
    Cmd_Op    = op;
    Cmd_A     = a;
    Cmd_B     = b;
    tick();
    Cmd_Valid = 1'b0;
    Cmd_Op    = 3'($urandom);
    Cmd_A     = $urandom;
    Cmd_B     = $urandom;
    lat = 1;
    while (!Rsp_Valid && lat < 20) begin
      tick();
      lat++;
    end
    check("latency", lat, elat);
    check("result", Rsp_Result, er);
    check("flag_z", 32'(Rsp_Z), 32'(ez));
    check("flag_c", 32'(Rsp_C), 32'(ec));
    check("flag_n", 32'(Rsp_N), 32'(en));
    check("ready_in_done", 32'(Cmd_Ready), 32'd0);
    check("busy_in_done", 32'(Busy), 32'd1);
    repeat (hold) begin
      tick();
      check("hold_valid", 32'(Rsp_Valid), 32'd1);
      check("hold_result", Rsp_Result, er);
      check("hold_flags", {29'd0, Rsp_Z, Rsp_C, Rsp_N}, {29'd0, ez, ec, en});
      check("hold_ready", 32'(Cmd_Ready), 32'd0);
    end
    Rsp_Ready = 1'b1;
    tick();
    Rsp_Ready = 1'b0;
    check("valid_after_hs", 32'(Rsp_Valid), 32'd0);
    check("ready_after_hs", 32'(Cmd_Ready), 32'd1);
    check("busy_after_hs", 32'(Busy), 32'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ready"}, 32'(Cmd_Ready), 32'd0);
    check({tag, "_busy"}, 32'(Busy), 32'd0);
    check({tag, "_valid"}, 32'(Rsp_Valid), 32'd0);
    check({tag, "_result"}, Rsp_Result, 32'd0);
    check({tag, "_flags"}, {29'd0, Rsp_Z, Rsp_C, Rsp_N}, 32'd0);
  endtask

  initial begin
    logic [2:0]  op;
    logic [31:0] a, b;
    rst       = 1'b1;
    Cmd_Valid = 1'b0;
    Cmd_Op    = '0;
    Cmd_A     = '0;
    Cmd_B     = '0;
    Rsp_Ready = 1'b0;
    tick();
    tick();
    check_reset_outputs("reset");
    rst = 1'b0;
    tick();
    check("ready_after_reset", 32'(Cmd_Ready), 32'd1);

    do_cmd(ALU_OP_ADD, 32'h1234_0001, 32'h0001_0002, 0);
    do_cmd(ALU_OP_ADD, 32'hFFFF_FFFF, 32'h0000_0001, 0);
    do_cmd(ALU_OP_SUB, 32'h0001_0000, 32'h0000_0001, 0);
    do_cmd(ALU_OP_SUB, 32'h0000_0000, 32'h0000_0001, 0);
    do_cmd(ALU_OP_ADD, 32'h8000_0000, 32'h8000_0000, 5);
    do_cmd(ALU_OP_SUB, 32'h1234_5678, 32'h1234_5678, 1);

    // Reset while the high half is in progress discards the command.
    Cmd_Valid = 1'b1;
    Cmd_Op    = ALU_OP_ADD;
    Cmd_A     = 32'h0000_FFFF;
    Cmd_B     = 32'h0000_0001;
    tick();
    Cmd_Valid = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_reset_outputs("mid_reset");
    tick();
    check("ready_after_mid_reset", 32'(Cmd_Ready), 32'd1);
    check("no_rsp_after_mid_reset", 32'(Rsp_Valid), 32'd0);
    do_cmd(ALU_OP_NOP, 32'hDEAD_BEEF, 32'h1234_5678, 0);
    do_cmd(ALU_OP_AND, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 2);

    for (int i = 0; i < 60; i++) begin
      case ($urandom_range(0, 3))
        0:       op = ALU_OP_ADD;
        1:       op = ALU_OP_SUB;
        2:       op = ALU_OP_ADD;
        default: op = 3'($urandom);
      endcase
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 3))
        0: begin a[15:0] = 16'hFFFF; b[15:0] = 16'h0001; end
        1: begin a[15:0] = 16'h0000; b[15:0] = 16'h0001; end
        2: b = a;
        default: ;
      endcase
      do_cmd(op, a, b, $urandom_range(0, 3));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
